// File: rtl/mdu_iter_if.sv
// mdu_iter_if -- request/response bundle for the iterative multiply/divide unit.
//
// Signals (named from the unit's point of view):
//   start_i        request strobe, accepted only when the unit is idle or done
//   op_i[2:0]      operation select (MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU)
//   a_i, b_i       multiplicand/dividend, multiplier/divisor
//   hi_i, lo_i     accumulator halves for MADD/MSUB
//   annul_i        cancel the in-flight operation
//   busy_o         operation in progress (pipeline stall)
//   ready_o        one-cycle pulse, result_o valid
//   result_o       {hi, lo}: product or {remainder, quotient}
//   div_by_zero_o  divisor was zero, valid with ready_o
//
// Modports: master drives requests (EX stage / bench), slave is the unit.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [2:0]           op_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic [WIDTH-1:0]     hi_i;
    logic [WIDTH-1:0]     lo_i;
    logic                 annul_i;
    logic                 busy_o;
    logic                 ready_o;
    logic [2*WIDTH-1:0]   result_o;
    logic                 div_by_zero_o;

    modport master (
        output start_i, op_i, a_i, b_i, hi_i, lo_i, annul_i,
        input  busy_o, ready_o, result_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, hi_i, lo_i, annul_i,
        output busy_o, ready_o, result_o, div_by_zero_o
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter -- iterative shared multiply/divide unit for the EX stage.
//
// Multiply retires MUL_BITS multiplier bits per cycle through a 2*WIDTH
// shift/add register; divide is radix-2 restoring, one quotient bit per cycle.
// Both work on magnitudes; FIX applies sign correction (and accumulation).
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   bus     mdu_iter_if.slave request/response bundle
//
// Parameters:
//   WIDTH    operand width (result is 2*WIDTH)
//   MUL_BITS multiplier bits per cycle, must divide WIDTH
//
// Build option:
//   MDU_MADD_EN  when defined, MADD/MADDU/MSUB/MSUBU accumulate into the
//                latched {hi_i, lo_i}; otherwise 1xx ops are plain multiplies.
module mdu_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mdu_iter_if.slave   bus
);
    localparam int MUL_STEPS = WIDTH / MUL_BITS;
    localparam int CNT_W     = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   p_q;        // mul: {partial hi, product/multiplier}; div: {rem, dividend/quot}
    logic [WIDTH-1:0]     opd_q;      // multiplicand magnitude or divisor magnitude
    logic [CNT_W-1:0]     cnt_q;
    logic                 sign_a_q;
    logic                 sign_b_q;
    logic                 is_div_q;
    logic                 busy_q;
    logic                 ready_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 dbz_q;
`ifdef MDU_MADD_EN
    logic                 acc_en_q;
    logic                 sub_q;
    logic [2*WIDTH-1:0]   acc_q;
`else
    logic                 unused_acc;
    assign unused_acc = ^{bus.hi_i, bus.lo_i};
`endif

    // Request decode and operand magnitudes at acceptance
    logic                 accept;
    logic                 is_div_in;
    logic                 sa_in;
    logic                 sb_in;
    logic [WIDTH-1:0]     mag_a_in;
    logic [WIDTH-1:0]     mag_b_in;

    always_comb begin
        accept    = bus.start_i && !bus.annul_i;
        is_div_in = !bus.op_i[2] && bus.op_i[1];
        sa_in     = !bus.op_i[0] && bus.a_i[WIDTH-1];
        sb_in     = !bus.op_i[0] && bus.b_i[WIDTH-1];
        mag_a_in  = sa_in ? ('0 - bus.a_i) : bus.a_i;
        mag_b_in  = sb_in ? ('0 - bus.b_i) : bus.b_i;
    end

    // One multiply step: add digit*multiplicand to the high half, then shift
    // the whole register right by MUL_BITS so finished product bits drop into
    // the low half as the consumed multiplier bits leave it.
    logic [WIDTH+MUL_BITS-1:0] mul_sum;
    logic [2*WIDTH-1:0]        mul_d;

    always_comb begin
        mul_sum = {{MUL_BITS{1'b0}}, p_q[2*WIDTH-1:WIDTH]}
                + ({{MUL_BITS{1'b0}}, opd_q} * {{WIDTH{1'b0}}, p_q[MUL_BITS-1:0]});
        mul_d   = {mul_sum, p_q[WIDTH-1:MUL_BITS]};
    end

    // One restoring-division step: shift the next dividend bit into the
    // remainder, subtract the divisor, keep the difference if no borrow.
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   div_d;

    always_comb begin
        rem_sh = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, opd_q};
        if (!diff[WIDTH]) begin
            div_d = {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end else begin
            div_d = {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction / accumulation applied on the way into DONE
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   fix_d;

    always_comb begin
        quot  = p_q[WIDTH-1:0];
        rem   = p_q[2*WIDTH-1:WIDTH];
        prod  = p_q;
        if (sign_a_q ^ sign_b_q) begin
            quot = '0 - quot;
            prod = '0 - prod;
        end
        if (sign_a_q) begin
            rem = '0 - rem;
        end
        if (is_div_q) begin
            fix_d = {rem, quot};
        end else begin
            fix_d = prod;
`ifdef MDU_MADD_EN
            if (acc_en_q) begin
                fix_d = sub_q ? (acc_q - prod) : (acc_q + prod);
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            opd_q    <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
`ifdef MDU_MADD_EN
            acc_en_q <= 1'b0;
            sub_q    <= 1'b0;
            acc_q    <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        sign_a_q <= sa_in;
                        sign_b_q <= sb_in;
                        is_div_q <= is_div_in;
                        cnt_q    <= '0;
`ifdef MDU_MADD_EN
                        acc_en_q <= bus.op_i[2];
                        sub_q    <= bus.op_i[1];
                        acc_q    <= {bus.hi_i, bus.lo_i};
`endif
                        if (is_div_in && (bus.b_i == '0)) begin
                            // Divide by zero bypasses DIV and FIX entirely
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            ready_q  <= 1'b1;
                            result_q <= {bus.a_i, {WIDTH{1'b1}}};
                            dbz_q    <= 1'b1;
                        end else if (is_div_in) begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                            p_q     <= {{WIDTH{1'b0}}, mag_a_in};
                            opd_q   <= mag_b_in;
                        end else begin
                            state_q <= S_MUL;
                            busy_q  <= 1'b1;
                            p_q     <= {{WIDTH{1'b0}}, mag_b_in};
                            opd_q   <= mag_a_in;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (bus.annul_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        p_q   <= mul_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_DIV: begin
                    if (bus.annul_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        p_q   <= div_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    if (bus.annul_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q  <= S_DONE;
                        ready_q  <= 1'b1;
                        result_q <= fix_d;
                        dbz_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.ready_o       = ready_q;
    assign bus.result_o      = result_q;
    assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter -- self-checking bench for mdu_iter (WIDTH=32, MUL_BITS=4).
// Directed cases plus randomized operations checked against an arithmetic
// reference model (64-bit integer multiply/divide).
module tb_mdu_iter;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [63:0] last_res;

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W), .MUL_BITS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_div_op(input logic [2:0] op);
        return (op[2] == 1'b0) && (op[1] == 1'b1);
    endfunction

    // Reference: plain 64-bit integer arithmetic on sign/zero-extended operands
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint ea, eb, q, r;
        logic [63:0] p, acc;
        ea  = op[0] ? longint'({32'b0, a}) : longint'({{32{a[31]}}, a});
        eb  = op[0] ? longint'({32'b0, b}) : longint'({{32{b[31]}}, b});
        acc = {hi, lo};
        if (is_div_op(op)) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = ea / eb;
            r = ea % eb;
            return {r[31:0], q[31:0]};
        end
        p = ea * eb;
`ifdef MDU_MADD_EN
        if (op[2]) p = op[1] ? (acc - p) : (acc + p);
`else
        if (acc == 64'd1) p = p; // accumulator inputs have no effect in this build
`endif
        return p;
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] b);
        if (is_div_op(op)) return (b == 32'd0) ? 1 : W + 2;
        return W / 4 + 2;
    endfunction

    // Drive a request during a cycle; returns #1 into cycle 1
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.hi_i    = hi;
        bus.lo_i    = lo;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        // Operands after acceptance must not matter
        bus.a_i  = $urandom;
        bus.b_i  = $urandom;
        bus.hi_i = $urandom;
        bus.lo_i = $urandom;
    endtask

    // Full operation; optional stray start in cycle 3. Returns #1 into DONE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input bit poke);
        logic [63:0] exp;
        int cyc;
        bit  busy_bad;
        exp = model(op, a, b, hi, lo);
        launch(op, a, b, hi, lo);
        cyc = 1;
        busy_bad = 1'b0;
        while (!bus.ready_o && cyc < 200) begin
            if (!bus.busy_o) busy_bad = 1'b1;
            if (poke && cyc == 3) begin
                bus.start_i = 1'b1;
                bus.op_i    = 3'b001;
            end else begin
                bus.start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start_i = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(exp_latency(op, b)));
        check({tag, "_busy_inflight"}, 64'(busy_bad), 64'd0);
        check({tag, "_busy_done"}, 64'(bus.busy_o), 64'd0);
        check({tag, "_result"}, bus.result_o, exp);
        check({tag, "_dbz"}, 64'(bus.div_by_zero_o),
              64'(is_div_op(op) && b == 32'd0));
        last_res = exp;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int seen;
        n_checks = 0;
        n_errors = 0;
        last_res = '0;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.op_i = '0;
        bus.a_i  = '0;
        bus.b_i  = '0;
        bus.hi_i = '0;
        bus.lo_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd0);
        check("rst_result", bus.result_o, 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero_o), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases; consecutive calls are back-to-back from DONE
        run_op("mult",  3'b000, 32'hFFFF_FFFE, 32'h3, 0, 0, 0);
        check("mult_exp", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", 3'b001, 32'hFFFF_FFFE, 32'h3, 0, 0, 0);
        check("multu_exp", bus.result_o, 64'h0000_0002_FFFF_FFFA);
        run_op("divu", 3'b011, 32'd100, 32'd7, 0, 0, 1);
        check("divu_exp", bus.result_o, 64'h0000_0002_0000_000E);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        check("div_neg_exp", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        check("div_ovf_exp", bus.result_o, 64'h0000_0000_8000_0000);
        run_op("dbz", 3'b011, 32'd5, 32'd0, 0, 0, 0);
        check("dbz_exp", bus.result_o, 64'h0000_0005_FFFF_FFFF);
        run_op("dbz_clear", 3'b011, 32'd6, 32'd3, 0, 0, 0);

        // ready_o is a single pulse; result holds
        @(posedge clk);
        #1;
        check("ready_pulse", 64'(bus.ready_o), 64'd0);
        check("result_hold", bus.result_o, last_res);

        // Annul in cycle 5 of a DIV; also a stray start in cycle 2
        launch(3'b010, 32'd1000, 32'd3, 0, 0);
        for (int c = 1; c < 5; c++) begin
            bus.start_i = (c == 2);
            @(posedge clk);
            #1;
        end
        bus.start_i = 1'b0;
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        check("annul_busy", 64'(bus.busy_o), 64'd0);
        check("annul_result", bus.result_o, last_res);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.ready_o) seen++;
            @(posedge clk);
            #1;
        end
        check("annul_no_ready", 64'(seen), 64'd0);

        // annul_i in DONE blocks acceptance
        run_op("pre_block", 3'b001, 32'd9, 32'd9, 0, 0, 0);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.annul_i = 1'b1;
        bus.op_i = 3'b011;
        bus.b_i  = 32'd0;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        check("block_ready", 64'(bus.ready_o), 64'd0);
        check("block_busy", 64'(bus.busy_o), 64'd0);
        check("block_dbz", 64'(bus.div_by_zero_o), 64'd0);

        // Reset in cycle 12 of a DIV
        launch(3'b010, 32'd12345, 32'd17, 0, 0);
        for (int c = 1; c < 12; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 64'(bus.busy_o), 64'd0);
        check("midrst_ready", 64'(bus.ready_o), 64'd0);
        check("midrst_result", bus.result_o, 64'd0);
        check("midrst_dbz", 64'(bus.div_by_zero_o), 64'd0);
        run_op("after_rst", 3'b001, 32'd3, 32'd4, 0, 0, 0);
        check("after_rst_exp", bus.result_o, 64'h0000_0000_0000_000C);

`ifdef MDU_MADD_EN
        run_op("maddu", 3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
        check("maddu_exp", bus.result_o, 64'h0000_0001_0000_0000);
        run_op("msub", 3'b110, 32'd1, 32'd1, 32'd0, 32'd0, 0);
        check("msub_exp", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", op, a, b, $urandom, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
